// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier built around one 4-bit ripple adder.
// A 4-step serial multiply with a start/busy/done handshake and a held 8-bit product.

module Adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module mul4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] m, m_nxt;
    logic [7:0] p, p_nxt, p_step;
    logic [1:0] cnt, cnt_nxt;
    logic [7:0] prod_nxt;
    logic [3:0] s;
    logic       co;

    Adder4 u_add (
        .a    (p[7:4]),
        .b    (m),
        .cin  (1'b0),
        .sum  (s),
        .cout (co)
    );

    // Upper half accumulates; the adder carry becomes the new MSB after the shift.
    assign p_step = p[0] ? {co, s, p[3:1]} : {1'b0, p[7:1]};

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        p_nxt     = p;
        cnt_nxt   = cnt;
        prod_nxt  = product;
        case (state)
            IDLE: begin
                if (start) begin
                    m_nxt     = a;
                    p_nxt     = {4'b0, b};
                    cnt_nxt   = 2'd0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                p_nxt   = p_step;
                cnt_nxt = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    prod_nxt  = p_step;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= 4'd0;
            p       <= 8'd0;
            cnt     <= 2'd0;
            product <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            m       <= m_nxt;
            p       <= p_nxt;
            cnt     <= cnt_nxt;
            product <= prod_nxt;
            // Status flags are registered from the next state so they align with it.
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: handshake timing, hold, abort and operand sweeps
// against an arithmetic reference (a*b).

module tb_mul4_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    mul4_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at a negedge; samples at the negedges after E0..E5, returns at the
    // negedge after E5 so the next call is accepted at E6.
    task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                         output logic [7:0] prod, output logic [7:0] prod_run,
                         output int done_at, output int done_cnt, output int busy_cnt,
                         output logic busy_end);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_at = -1; done_cnt = 0; busy_cnt = 0; prod = 8'hxx; prod_run = product;
        for (int k = 0; k < 6; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 2) prod_run = product;
            if (k == 4) prod = product;
            busy_end = busy;
            if (k < 5) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b product=%h, required 0 0 00", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max();
        logic [7:0] pr, prr; int da, dc, bc; logic be;
        do_op(4'd15, 4'd15, pr, prr, da, dc, bc, be);
        checks++;
        if (pr !== 8'hE1) begin
            errors++; $display("FAIL max_product: got %h required e1", pr);
        end
        checks++;
        if (da !== 4 || dc !== 1) begin
            errors++; $display("FAIL max_done_timing: done_at=%0d cnt=%0d required 4 1", da, dc);
        end
        checks++;
        if (bc !== 5 || be !== 1'b0) begin
            errors++; $display("FAIL max_busy: busy_cycles=%0d busy_after_E5=%b required 5 0", bc, be);
        end
    endtask

    task automatic test_hold();
        logic [7:0] pr, prr; int da, dc, bc; logic be;
        logic [3:0] xs [3] = '{4'd13, 4'd0, 4'd7};
        logic [3:0] ys [3] = '{4'd11, 4'd9, 4'd0};
        logic [7:0] prev;
        prev = product;
        for (int i = 0; i < 3; i++) begin
            do_op(xs[i], ys[i], pr, prr, da, dc, bc, be);
            checks++;
            if (pr !== {4'b0, xs[i]} * {4'b0, ys[i]}) begin
                errors++;
                $display("FAIL hold_product[%0d]: got %h required %h", i, pr, {4'b0, xs[i]} * {4'b0, ys[i]});
            end
            checks++;
            if (prr !== prev) begin
                errors++; $display("FAIL hold_during_run[%0d]: got %h required %h", i, prr, prev);
            end
            prev = {4'b0, xs[i]} * {4'b0, ys[i]};
        end
    endtask

    task automatic test_ignore_start();
        int done_seen = 0;
        int busy_low_k = -1;
        logic [7:0] p1 = 8'hxx, p2 = 8'hxx;
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(negedge clk);
        a = 4'd9; b = 4'd9;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                done_seen++;
                if (k == 4) p1 = product;
                if (k == 10) p2 = product;
            end
            if (!busy && busy_low_k < 0) busy_low_k = k;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (p1 !== 8'd15) begin
            errors++; $display("FAIL ignore_first: got %h required 0f", p1);
        end
        checks++;
        if (p2 !== 8'd81) begin
            errors++; $display("FAIL ignore_second: got %h required 51", p2);
        end
        checks++;
        if (done_seen !== 2 || busy_low_k !== 5) begin
            errors++;
            $display("FAIL ignore_handshake: dones=%0d busy_low_at=%0d required 2 5", done_seen, busy_low_k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] pr, prr; int da, dc, bc; logic be;
        int dpulse = 0;
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b product=%h required 0 0 00", busy, done, product);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) dpulse++;
            if (k == 1) rst_n = 1'b1;
        end
        checks++;
        if (dpulse !== 0) begin
            errors++; $display("FAIL abort_no_done: pulses=%0d required 0", dpulse);
        end
        do_op(4'd2, 4'd3, pr, prr, da, dc, bc, be);
        checks++;
        if (pr !== 8'd6 || dc !== 1) begin
            errors++; $display("FAIL abort_recover: got %h dones=%0d required 06 1", pr, dc);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] pr, prr; int da, dc, bc; logic be;
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] x, y;
            x = 4'(i >> 4); y = 4'(i);
            do_op(x, y, pr, prr, da, dc, bc, be);
            checks++;
            if (pr !== {4'b0, x} * {4'b0, y} || dc !== 1 || da !== 4) begin
                errors++; bad++;
                if (bad < 8)
                    $display("FAIL sweep %0d*%0d: got %h done_cnt=%0d done_at=%0d required %h 1 4",
                             x, y, pr, dc, da, {4'b0, x} * {4'b0, y});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pr, prr; int da, dc, bc; logic be;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] x, y;
            x = 4'($urandom_range(15)); y = 4'($urandom_range(15));
            do_op(x, y, pr, prr, da, dc, bc, be);
            if ($urandom_range(1)) repeat ($urandom_range(3)) @(negedge clk);
            checks++;
            if (pr !== {4'b0, x} * {4'b0, y} || dc !== 1) begin
                errors++;
                $display("FAIL random %0d*%0d: got %h dones=%0d required %h 1", x, y, pr, dc, {4'b0, x} * {4'b0, y});
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_hold();
        test_ignore_start();
        test_abort();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end
endmodule
